// File: rtl/sw_seq_feeder.sv
// Job loader for the Smith-Waterman core: buffers packed reference/query bases, streams them,
// then returns the core's result. Optional watchdog in WAIT is enabled by SW_FEEDER_TIMEOUT_EN.
module sw_seq_feeder #(
    parameter int REF_LEN         = 64,
    parameter int QUERY_LEN       = 48,
    parameter int WIDTH_SCORE     = 8,
    parameter int WIDTH_POS_REF   = 7,
    parameter int WIDTH_POS_QUERY = 6,
    parameter int TIMEOUT_CYCLES  = 4096
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [7:0]                 in_data,
    output logic                       sw_valid,
    output logic [1:0]                 sw_data_ref,
    output logic [1:0]                 sw_data_query,
    input  logic                       sw_finish,
    input  logic [WIDTH_SCORE-1:0]     sw_max,
    input  logic [WIDTH_POS_REF-1:0]   sw_pos_ref,
    input  logic [WIDTH_POS_QUERY-1:0] sw_pos_query,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [WIDTH_SCORE-1:0]     res_max,
    output logic [WIDTH_POS_REF-1:0]   res_pos_ref,
    output logic [WIDTH_POS_QUERY-1:0] res_pos_query,
    output logic                       res_err,
    output logic                       busy
);

    localparam int REF_WORDS   = REF_LEN / 4;
    localparam int TOTAL_WORDS = (REF_LEN + QUERY_LEN) / 4;
    localparam int BASE_W      = $clog2(REF_LEN);
    localparam int WCNT_W      = $clog2(TOTAL_WORDS + 1);

    localparam logic [1:0] ST_LOAD   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_RESULT = 2'd3;

    logic [1:0]                 state_q, state_d;
    logic [WCNT_W-1:0]          word_cnt_q, word_cnt_d;
    logic [BASE_W-1:0]          base_cnt_q, base_cnt_d;
    logic [2*REF_LEN-1:0]       ref_buf_q, ref_buf_d;
    logic [2*QUERY_LEN-1:0]     query_buf_q, query_buf_d;
    logic                       sw_valid_q, sw_valid_d;
    logic [1:0]                 sw_ref_q, sw_ref_d;
    logic [1:0]                 sw_query_q, sw_query_d;
    logic [WIDTH_SCORE-1:0]     res_max_q, res_max_d;
    logic [WIDTH_POS_REF-1:0]   res_pos_ref_q, res_pos_ref_d;
    logic [WIDTH_POS_QUERY-1:0] res_pos_query_q, res_pos_query_d;

`ifdef SW_FEEDER_TIMEOUT_EN
    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES);
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              res_err_q, res_err_d;
`endif

    always_comb begin
        state_d         = state_q;
        word_cnt_d      = word_cnt_q;
        base_cnt_d      = base_cnt_q;
        ref_buf_d       = ref_buf_q;
        query_buf_d     = query_buf_q;
        sw_valid_d      = sw_valid_q;
        sw_ref_d        = sw_ref_q;
        sw_query_d      = sw_query_q;
        res_max_d       = res_max_q;
        res_pos_ref_d   = res_pos_ref_q;
        res_pos_query_d = res_pos_query_q;
`ifdef SW_FEEDER_TIMEOUT_EN
        wdog_d          = wdog_q;
        res_err_d       = res_err_q;
`endif
        unique case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    if (word_cnt_q < WCNT_W'(REF_WORDS)) begin
                        ref_buf_d[int'(word_cnt_q)*8 +: 8] = in_data;
                    end else begin
                        query_buf_d[(int'(word_cnt_q) - REF_WORDS)*8 +: 8] = in_data;
                    end
                    if (word_cnt_q == WCNT_W'(TOTAL_WORDS - 1)) begin
                        // Base 0 may live in the word accepted this cycle, so use the merged buffers.
                        state_d    = ST_STREAM;
                        word_cnt_d = '0;
                        base_cnt_d = '0;
                        sw_valid_d = 1'b1;
                        sw_ref_d   = ref_buf_d[1:0];
                        sw_query_d = query_buf_d[1:0];
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                end
            end
            ST_STREAM: begin
                if (base_cnt_q == BASE_W'(REF_LEN - 1)) begin
                    state_d    = ST_WAIT;
                    base_cnt_d = '0;
                    sw_valid_d = 1'b0;
                    sw_ref_d   = 2'b00;
                    sw_query_d = 2'b00;
                end else begin
                    base_cnt_d = base_cnt_q + 1'b1;
                    sw_ref_d   = ref_buf_q[int'(base_cnt_d)*2 +: 2];
                    if (int'(base_cnt_d) < QUERY_LEN) begin
                        sw_query_d = query_buf_q[int'(base_cnt_d)*2 +: 2];
                    end else begin
                        sw_query_d = 2'b00;
                    end
                end
            end
            ST_WAIT: begin
                if (sw_finish) begin
                    state_d         = ST_RESULT;
                    res_max_d       = sw_max;
                    res_pos_ref_d   = sw_pos_ref;
                    res_pos_query_d = sw_pos_query;
`ifdef SW_FEEDER_TIMEOUT_EN
                    res_err_d       = 1'b0;
                    wdog_d          = '0;
                end else if (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d         = ST_RESULT;
                    res_max_d       = '0;
                    res_pos_ref_d   = '0;
                    res_pos_query_d = '0;
                    res_err_d       = 1'b1;
                    wdog_d          = '0;
                end else begin
                    wdog_d = wdog_q + 1'b1;
`endif
                end
            end
            ST_RESULT: begin
                if (res_ready) begin
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_LOAD;
            word_cnt_q      <= '0;
            base_cnt_q      <= '0;
            ref_buf_q       <= '0;
            query_buf_q     <= '0;
            sw_valid_q      <= 1'b0;
            sw_ref_q        <= 2'b00;
            sw_query_q      <= 2'b00;
            res_max_q       <= '0;
            res_pos_ref_q   <= '0;
            res_pos_query_q <= '0;
`ifdef SW_FEEDER_TIMEOUT_EN
            wdog_q          <= '0;
            res_err_q       <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            word_cnt_q      <= word_cnt_d;
            base_cnt_q      <= base_cnt_d;
            ref_buf_q       <= ref_buf_d;
            query_buf_q     <= query_buf_d;
            sw_valid_q      <= sw_valid_d;
            sw_ref_q        <= sw_ref_d;
            sw_query_q      <= sw_query_d;
            res_max_q       <= res_max_d;
            res_pos_ref_q   <= res_pos_ref_d;
            res_pos_query_q <= res_pos_query_d;
`ifdef SW_FEEDER_TIMEOUT_EN
            wdog_q          <= wdog_d;
            res_err_q       <= res_err_d;
`endif
        end
    end

    assign in_ready      = (state_q == ST_LOAD);
    assign busy          = (state_q != ST_LOAD);
    assign res_valid     = (state_q == ST_RESULT);
    assign sw_valid      = sw_valid_q;
    assign sw_data_ref   = sw_ref_q;
    assign sw_data_query = sw_query_q;
    assign res_max       = res_max_q;
    assign res_pos_ref   = res_pos_ref_q;
    assign res_pos_query = res_pos_query_q;
`ifdef SW_FEEDER_TIMEOUT_EN
    assign res_err       = res_err_q;
`else
    assign res_err       = 1'b0;
`endif

endmodule

// File: tb/tb_sw_seq_feeder.sv
// Randomized bench for sw_seq_feeder: a word-array model predicts each streamed base and result.
module tb_sw_seq_feeder;

    localparam int REF_LEN        = 64;
    localparam int QUERY_LEN      = 48;
    localparam int REF_WORDS      = REF_LEN / 4;
    localparam int TOTAL_WORDS    = (REF_LEN + QUERY_LEN) / 4;
    localparam int TIMEOUT_CYCLES = 4096;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       sw_finish = 1'b0;
    logic [7:0] sw_max = '0;
    logic [6:0] sw_pos_ref = '0;
    logic [5:0] sw_pos_query = '0;
    logic       res_ready = 1'b0;

    logic       in_ready, sw_valid, res_valid, res_err, busy;
    logic [1:0] sw_data_ref, sw_data_query;
    logic [7:0] res_max;
    logic [6:0] res_pos_ref;
    logic [5:0] res_pos_query;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] words [TOTAL_WORDS];

    sw_seq_feeder dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .sw_valid     (sw_valid),
        .sw_data_ref  (sw_data_ref),
        .sw_data_query(sw_data_query),
        .sw_finish    (sw_finish),
        .sw_max       (sw_max),
        .sw_pos_ref   (sw_pos_ref),
        .sw_pos_query (sw_pos_query),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_max      (res_max),
        .res_pos_ref  (res_pos_ref),
        .res_pos_query(res_pos_query),
        .res_err      (res_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation still running, required to finish");
        $fatal(1);
    end

    // Reference model: base k is bit pair k%4 of word k/4 (earliest base in the low bits).
    function automatic logic [1:0] ref_base(input int k);
        logic [7:0] w;
        w = words[k / 4];
        return 2'((w >> (2 * (k % 4))) & 8'h03);
    endfunction

    function automatic logic [1:0] query_base(input int k);
        logic [7:0] w;
        if (k >= QUERY_LEN) return 2'b00;
        w = words[REF_WORDS + k / 4];
        return 2'((w >> (2 * (k % 4))) & 8'h03);
    endfunction

    task automatic fill_words(input bit fixed);
        for (int i = 0; i < TOTAL_WORDS; i++) words[i] = fixed ? 8'hE4 : 8'($urandom);
    endtask

    task automatic send_job(input bit gaps);
        int   n = 0;
        int   guard = 0;
        logic rdy;
        while (n < TOTAL_WORDS && guard < 2000) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end else begin
                in_valid = 1'b1;
                in_data  = words[n];
            end
            vectors++;
            if (in_ready !== 1'b1 || sw_valid !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL load_idle: in_ready=%b sw_valid=%b busy=%b, required 1/0/0",
                         in_ready, sw_valid, busy);
            end
            rdy = in_ready;
            @(posedge clk); #1;
            if (in_valid && rdy) n++;
            guard++;
        end
        in_valid = 1'b0;
        vectors++;
        if (n != TOTAL_WORDS) begin
            miscompares++;
            $display("FAIL load_accept: accepted %0d words, required %0d", n, TOTAL_WORDS);
        end
    endtask

    task automatic check_stream(input int ncycles, input bit noise);
        for (int k = 0; k < ncycles; k++) begin
            vectors++;
            if (sw_valid !== 1'b1 || sw_data_ref !== ref_base(k) ||
                sw_data_query !== query_base(k) || in_ready !== 1'b0 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL stream_k%0d: valid=%b ref=%0d query=%0d in_ready=%b busy=%b, required 1/%0d/%0d/0/1",
                         k, sw_valid, sw_data_ref, sw_data_query, in_ready, busy,
                         ref_base(k), query_base(k));
            end
            if (noise) begin
                in_valid  = 1'($urandom_range(0, 1));
                in_data   = 8'($urandom);
                sw_finish = 1'($urandom_range(0, 1));
                sw_max    = 8'($urandom);
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        sw_finish = 1'b0;
        if (ncycles == REF_LEN) begin
            vectors++;
            if (sw_valid !== 1'b0 || sw_data_ref !== 2'b00 || sw_data_query !== 2'b00 ||
                busy !== 1'b1 || res_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL stream_end: valid=%b ref=%0d query=%0d busy=%b res_valid=%b, required 0/0/0/1/0",
                         sw_valid, sw_data_ref, sw_data_query, busy, res_valid);
            end
        end
    endtask

    task automatic do_result(input logic [7:0] mx, input logic [6:0] pr, input logic [5:0] pq,
                             input int hold, input bit early);
        sw_finish    = 1'b1;
        sw_max       = mx;
        sw_pos_ref   = pr;
        sw_pos_query = pq;
        res_ready    = early;
        @(posedge clk); #1;
        sw_finish    = 1'b0;
        sw_max       = ~mx;
        sw_pos_ref   = ~pr;
        sw_pos_query = ~pq;
        for (int c = 0; c <= hold; c++) begin
            vectors++;
            if (res_valid !== 1'b1 || res_max !== mx || res_pos_ref !== pr ||
                res_pos_query !== pq || res_err !== 1'b0 || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL result_hold_c%0d: valid=%b max=%0d pr=%0d pq=%0d err=%b in_ready=%b, required 1/%0d/%0d/%0d/0/0",
                         c, res_valid, res_max, res_pos_ref, res_pos_query, res_err, in_ready,
                         mx, pr, pq);
            end
            if (early) break;
            if (c < hold) begin
                @(posedge clk); #1;
            end
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL result_taken: in_ready=%b res_valid=%b busy=%b, required 1/0/0",
                     in_ready, res_valid, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: in_ready=%b busy=%b, required 1/0", in_ready, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (in_ready !== 1'b1 || sw_valid !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0 ||
            res_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: in_ready=%b sw_valid=%b res_valid=%b busy=%b err=%b, required 1/0/0/0/0",
                     in_ready, sw_valid, res_valid, busy, res_err);
        end
        vectors++;
        if (sw_data_ref !== 2'b00 || sw_data_query !== 2'b00 || res_max !== 8'd0 ||
            res_pos_ref !== 7'd0 || res_pos_query !== 6'd0) begin
            miscompares++;
            $display("FAIL reset_data: ref=%0d query=%0d max=%0d pr=%0d pq=%0d, required all 0",
                     sw_data_ref, sw_data_query, res_max, res_pos_ref, res_pos_query);
        end
    endtask

    task automatic test_stream_nogap();
        fill_words(1'b1);
        send_job(1'b0);
        check_stream(REF_LEN, 1'b0);
        do_result(8'($urandom), 7'($urandom), 6'($urandom), 2, 1'b0);
    endtask

    task automatic test_gaps();
        fill_words(1'b1);
        send_job(1'b1);
        check_stream(REF_LEN, 1'b1);
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
            vectors++;
            if (in_ready !== 1'b0 || busy !== 1'b1 || res_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL wait_idle_c%0d: in_ready=%b busy=%b res_valid=%b, required 0/1/0",
                         c, in_ready, busy, res_valid);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        do_result(8'($urandom), 7'($urandom), 6'($urandom), 1, 1'b0);
    endtask

    task automatic test_result();
        fill_words(1'b0);
        send_job(1'b0);
        check_stream(REF_LEN, 1'b0);
        do_result(8'h60, 7'd64, 6'd48, 5, 1'b0);
        fill_words(1'b0);
        send_job(1'b1);
        check_stream(REF_LEN, 1'b0);
        do_result(8'($urandom), 7'($urandom), 6'($urandom), 0, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j < 3; j++) begin
            fill_words(1'b0);
            send_job(1'($urandom_range(0, 1)));
            check_stream(REF_LEN, 1'($urandom_range(0, 1)));
            do_result(8'($urandom), 7'($urandom), 6'($urandom), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset_mid();
        fill_words(1'b0);
        send_job(1'b0);
        check_stream(30, 1'b0);
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (sw_valid !== 1'b0 || sw_data_ref !== 2'b00 || sw_data_query !== 2'b00 ||
            in_ready !== 1'b1 || busy !== 1'b0 || res_max !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_mid: valid=%b ref=%0d query=%0d in_ready=%b busy=%b max=%0d, required 0/0/0/1/0/0",
                     sw_valid, sw_data_ref, sw_data_query, in_ready, busy, res_max);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        fill_words(1'b0);
        send_job(1'b1);
        check_stream(REF_LEN, 1'b0);
        do_result(8'($urandom), 7'($urandom), 6'($urandom), 1, 1'b0);
    endtask

`ifdef SW_FEEDER_TIMEOUT_EN
    task automatic test_timeout();
        int n = 0;
        fill_words(1'b0);
        send_job(1'b0);
        check_stream(REF_LEN, 1'b0);
        while (res_valid !== 1'b1 && n < TIMEOUT_CYCLES + 20) begin
            @(posedge clk); #1;
            n++;
        end
        vectors++;
        if (n != TIMEOUT_CYCLES || res_err !== 1'b1 || res_max !== 8'd0 ||
            res_pos_ref !== 7'd0 || res_pos_query !== 6'd0) begin
            miscompares++;
            $display("FAIL timeout: cycles=%0d err=%b max=%0d pr=%0d pq=%0d, required %0d/1/0/0/0",
                     n, res_err, res_max, res_pos_ref, res_pos_query, TIMEOUT_CYCLES);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || res_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_taken: in_ready=%b res_valid=%b, required 1/0",
                     in_ready, res_valid);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream_nogap();
        test_gaps();
        test_result();
        test_back_to_back();
        test_reset_mid();
`ifdef SW_FEEDER_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
